instr_fetch_unit: RTL

//  - Instruction source for the datapath/controller pair: holds a program in a local word memory, steps a PC, drives Instr.
//  - Issues one 32-bit instruction per clock unless stalled; stops on a HALT word or at end of memory.
//  - Replaces hand-driven Instr stimulus with a self-sequencing fetch front end.

---
 rtl/instr_fetch_unit_pkg.sv | 33 +++
 rtl/instr_fetch_unit_rom.sv | 23 ++
 rtl/instr_fetch_unit.sv | 101 ++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared ISA definitions for the fetch front end: opcode values, FSM state type
// and opcode helpers used by the fetch unit and the controller.
package instr_fetch_unit_pkg;

  localparam logic [5:0] OP_HALT        = 6'b000000;
  localparam logic [5:0] OP_ADD         = 6'd1;
  localparam logic [5:0] OP_SUB         = 6'd2;
  localparam logic [5:0] OP_INC         = 6'd3;
  localparam logic [5:0] OP_DEC         = 6'd4;
  localparam logic [5:0] OP_AND         = 6'd5;
  localparam logic [5:0] OP_OR          = 6'd6;
  localparam logic [5:0] OP_XOR         = 6'd7;
  localparam logic [5:0] OP_NOT         = 6'd8;
  localparam logic [5:0] OP_SHIFT_LEFT  = 6'd9;
  localparam logic [5:0] OP_SHIFT_RIGHT = 6'd10;
  localparam logic [5:0] OP_ADDI        = 6'd11;
  localparam logic [5:0] OP_SUBI        = 6'd12;
  localparam logic [5:0] OP_COMPARE     = 6'd13;
  localparam logic [5:0] OP_LW          = 6'b100010;
  localparam logic [5:0] OP_SW          = 6'b101011;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HALT} ifu_state_t;

  function automatic logic is_isa_op(input logic [5:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_INC, OP_DEC, OP_AND, OP_OR, OP_XOR, OP_NOT,
      OP_SHIFT_LEFT, OP_SHIFT_RIGHT, OP_ADDI, OP_SUBI, OP_COMPARE,
      OP_LW, OP_SW: return 1'b1;
      default:      return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/instr_fetch_unit_rom.sv
// Program word memory: 2**ADDR_W x DATA_W, synchronous write, asynchronous read.
// No reset, so a program survives a core reset.
module instr_fetch_unit_rom #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/instr_fetch_unit.sv
// Self-sequencing instruction fetch: one word per clock from local memory until HALT or end of memory.
// Optional opcode screening (illegal_op port) is enabled by defining IFU_OPCODE_CHECK_EN.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int         ADDR_W  = 6,
  parameter int         DATA_W  = 32,
  parameter logic [5:0] HALT_OP = OP_HALT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stall,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] Instr,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              done,
  output logic [15:0]       issue_cnt
`ifdef IFU_OPCODE_CHECK_EN
  , output logic            illegal_op
`endif
);

  localparam logic [ADDR_W-1:0] PC_LAST = {ADDR_W{1'b1}};

  ifu_state_t        state;
  logic [DATA_W-1:0] word;
  logic [5:0]        op;
  // Set once the last memory word has been issued; pc parks there instead of wrapping.
  logic              at_end;

  instr_fetch_unit_rom #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_rom (
    .clk     (clk),
    .wr_en   (load_en && (state != ST_RUN)),
    .wr_addr (load_addr),
    .wr_data (load_data),
    .rd_addr (pc),
    .rd_data (word)
  );

  assign op   = word[DATA_W-1 -: 6];
  assign busy = (state == ST_RUN);
  assign done = (state == ST_HALT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      Instr       <= '0;
      instr_valid <= 1'b0;
      pc          <= '0;
      issue_cnt   <= '0;
      at_end      <= 1'b0;
`ifdef IFU_OPCODE_CHECK_EN
      illegal_op  <= 1'b0;
`endif
    end else begin
      case (state)
        ST_RUN: begin
          if (!stall) begin
            if (at_end || op == HALT_OP) begin
              Instr       <= '0;
              instr_valid <= 1'b0;
              state       <= ST_HALT;
`ifdef IFU_OPCODE_CHECK_EN
            end else if (!is_isa_op(op)) begin
              Instr       <= '0;
              instr_valid <= 1'b0;
              illegal_op  <= 1'b1;
              state       <= ST_HALT;
`endif
            end else begin
              Instr       <= word;
              instr_valid <= 1'b1;
              if (pc == PC_LAST) at_end <= 1'b1;
              else               pc     <= pc + ADDR_W'(1);
              if (issue_cnt != 16'hFFFF) issue_cnt <= issue_cnt + 16'd1;
            end
          end
        end
        default: begin
          Instr       <= '0;
          instr_valid <= 1'b0;
          if (start) begin
            state     <= ST_RUN;
            pc        <= '0;
            issue_cnt <= '0;
            at_end    <= 1'b0;
`ifdef IFU_OPCODE_CHECK_EN
            illegal_op <= 1'b0;
`endif
          end
        end
      endcase
    end
  end

endmodule
